// File: rtl/magnitude_comparator_serial.sv
// magnitude_comparator_serial
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, and reports one-hot L/E/G with a start/done handshake.
// Signed compares are handled by flipping both operand MSBs on capture
// (offset binary), after which the plain unsigned digit walk gives the signed
// answer.
// Optional feature macro: EARLY_TERM_EN -- when defined, a compare finishes on
// the edge that finds the first differing digit instead of always taking NDIG
// cycles.
module magnitude_comparator_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             gt_q, gt_d;
  logic             done_q, done_d;
  logic             l_q, l_d;
  logic             e_q, e_d;
  logic             g_q, g_d;

  logic [DIGIT-1:0] digA, digB;
  logic             digGt, digLt;
  logic             resDiff, resGt, finish;

  assign digA  = a_q[WIDTH-1 -: DIGIT];
  assign digB  = b_q[WIDTH-1 -: DIGIT];
  assign digGt = (digA > digB);
  assign digLt = (digA < digB);

  // Next-state logic: capture on start, then one digit per cycle; the first
  // differing digit is remembered and decides the final result.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    gt_d    = gt_q;
    done_d  = 1'b0;
    l_d     = l_q;
    e_d     = e_q;
    g_d     = g_q;
    resDiff = dec_q | digGt | digLt;
    resGt   = dec_q ? gt_q : digGt;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {x1[WIDTH-1] ^ sgn, x1[WIDTH-2:0]};
          b_d     = {x2[WIDTH-1] ^ sgn, x2[WIDTH-2:0]};
          cnt_d   = CW'(NDIG - 1);
          dec_d   = 1'b0;
          gt_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q - 1'b1;
        dec_d = resDiff;
        gt_d  = resGt;
`ifdef EARLY_TERM_EN
        finish = (cnt_q == '0) | resDiff;
`else
        finish = (cnt_q == '0);
`endif
        if (finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
          g_d     = resDiff & resGt;
          l_d     = resDiff & ~resGt;
          e_d     = ~resDiff;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      gt_q    <= 1'b0;
      done_q  <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      gt_q    <= gt_d;
      done_q  <= done_d;
      l_q     <= l_d;
      e_q     <= e_d;
      g_q     <= g_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign L    = l_q;
  assign E    = e_q;
  assign G    = g_q;

endmodule
